// File: rtl/fifo_read_ctrl.sv
// Async FIFO read side: wptr sync, read pointer, registered empty, fill level, registered output stage.
// Latency: wptr change to dout_valid takes 4 rclk edges; one word per rclk while dout_ready stays high.
module fifo_read_ctrl #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic [ADDRSIZE:0]   wptr,
  input  logic [DATASIZE-1:0] rdata,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic [DATASIZE-1:0] dout,
  output logic                dout_valid,
  input  logic                dout_ready
);

  logic [ADDRSIZE:0] wq1, wq2;
  logic [ADDRSIZE:0] rbin, rbinnext, rgraynext;
  logic [ADDRSIZE:0] wbin_s;
  logic              pop;

  // Refill the output register whenever it is empty or being drained this cycle.
  assign pop       = !rempty && (!dout_valid || dout_ready);
  assign rbinnext  = rbin + {{ADDRSIZE{1'b0}}, pop};
  assign rgraynext = (rbinnext >> 1) ^ rbinnext;
  assign raddr     = rbin[ADDRSIZE-1:0];

  always_comb begin
    wbin_s = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      wbin_s[i] = ^(wq2 >> i);
    end
  end

  // Pessimistic: wq2 lags the writer and the word parked in dout is not counted.
  assign rlevel = wbin_s - rbin;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      wq1        <= '0;
      wq2        <= '0;
      rbin       <= '0;
      rptr       <= '0;
      rempty     <= 1'b1;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      wq1    <= wptr;
      wq2    <= wq1;
      rbin   <= rbinnext;
      rptr   <= rgraynext;
      rempty <= (rgraynext == wq2);
      if (pop) begin
        dout       <= rdata;
        dout_valid <= 1'b1;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl: directed steps plus randomized traffic against a queue-based reference.
module tb_fifo_read_ctrl;

  logic       rclk = 1'b0;
  logic       rrst;
  logic [4:0] wptr;
  logic [7:0] rdata;
  logic [3:0] raddr;
  logic [4:0] rptr;
  logic       rempty;
  logic [4:0] rlevel;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;

  logic [7:0] mem [16];
  assign rdata = mem[raddr];

  always #5 rclk = ~rclk;

  fifo_read_ctrl #(.DATASIZE(8), .ADDRSIZE(4)) dut (
    .rclk       (rclk),
    .rrst       (rrst),
    .wptr       (wptr),
    .rdata      (rdata),
    .raddr      (raddr),
    .rptr       (rptr),
    .rempty     (rempty),
    .rlevel     (rlevel),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  int checks = 0;
  int errors = 0;

  // Reference: words written by the bench, words handed to the consumer, and
  // the write count as seen 1/2/3 edges ago (two-flop sync plus registered empty).
  int         wr_cnt, del_cnt, wb_d1, wb_d2, wb_d3;
  logic [7:0] expq [$];
  int         wraps, msb_tog;

  function automatic logic [4:0] gray(input int b);
    logic [4:0] v;
    v = b[4:0];
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    wr_cnt = 0; del_cnt = 0;
    wb_d1 = 0; wb_d2 = 0; wb_d3 = 0;
    expq.delete();
    wptr = '0;
  endtask

  task automatic write_word(input logic [7:0] d);
    mem[wr_cnt % 16] = d;
    expq.push_back(d);
    wr_cnt++;
    wptr = gray(wr_cnt);
  endtask

  // One rclk cycle: drive ready, score the handshake, then check state after the edge.
  task automatic tick(input logic rdy);
    logic       held;
    logic [7:0] hold_val;
    logic [3:0] pa;
    logic       pm;
    int         rb;
    dout_ready = rdy;
    held     = dout_valid && !rdy;
    hold_val = dout;
    pa       = raddr;
    pm       = rptr[4];
    if (dout_valid && rdy) begin
      chk("queue_nonempty", expq.size() > 0, 1);
      if (expq.size() > 0) chk("data", dout, expq.pop_front());
      del_cnt++;
    end
    @(posedge rclk);
    wb_d3 = wb_d2; wb_d2 = wb_d1; wb_d1 = wr_cnt;
    @(negedge rclk);
    if (held) begin
      chk("hold_dout", dout, hold_val);
      chk("hold_valid", dout_valid, 1);
    end
    rb = del_cnt + (dout_valid ? 1 : 0);
    chk("rptr", rptr, gray(rb));
    chk("raddr", raddr, rb % 16);
    chk("rlevel", rlevel, (wb_d2 - rb) & 31);
    chk("rempty", rempty, (rb & 31) == (wb_d3 & 31));
    if (pa == 4'd15 && raddr == 4'd0) wraps++;
    if (pm != rptr[4]) msb_tog++;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rempty"}, rempty, 1);
    chk({tag, "_valid"}, dout_valid, 0);
    chk({tag, "_rptr"}, rptr, 0);
    chk({tag, "_raddr"}, raddr, 0);
    chk({tag, "_rlevel"}, rlevel, 0);
    chk({tag, "_dout"}, dout, 0);
  endtask

  initial begin
    int target, cyc;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    rrst = 1'b1;
    dout_ready = 1'b0;
    wraps = 0; msb_tog = 0;
    model_reset();
    #1;
    check_reset_outputs("por");
    @(negedge rclk);
    rrst = 1'b0;

    // Single word: empty falls on edge 3, data on edge 4, drained on edge 5.
    write_word(8'hA5);
    tick(1); tick(1);
    chk("sw_e2_rempty", rempty, 1);
    tick(1);
    chk("sw_e3_rempty", rempty, 0);
    chk("sw_e3_valid", dout_valid, 0);
    tick(1);
    chk("sw_e4_valid", dout_valid, 1);
    chk("sw_e4_dout", dout, 8'hA5);
    tick(1);
    chk("sw_e5_rempty", rempty, 1);
    chk("sw_e5_rptr", rptr, 5'b00001);
    chk("sw_e5_valid", dout_valid, 0);

    // Reset in the middle of a cycle while a word is held in dout.
    write_word(8'h11); write_word(8'h22);
    for (int i = 0; i < 5; i++) tick(0);
    chk("pre_rst_valid", dout_valid, 1);
    #2;
    rrst = 1'b1;
    model_reset();
    #1;
    check_reset_outputs("mid");
    @(negedge rclk);
    rrst = 1'b0;

    // Fill 16 words and drain at full rate.
    for (int i = 0; i < 16; i++) write_word(i[7:0]);
    chk("fill_wptr", wptr, 5'b11000);
    tick(1); tick(1);
    chk("fill_level", rlevel, 16);
    tick(1);
    chk("fill_level_e3", rlevel, 16);
    for (int i = 0; i < 16; i++) begin
      tick(1);
      chk("drain_nogap", dout_valid, 1);
    end
    tick(1);
    chk("drain_valid", dout_valid, 0);
    chk("drain_rempty", rempty, 1);
    chk("drain_rptr", rptr, 5'b11000);
    chk("drain_all", del_cnt, 16);

    // Backpressure: exactly one word moves into dout, the rest stay in memory.
    write_word(8'h3C); write_word(8'h4D); write_word(8'h5E);
    for (int i = 0; i < 6; i++) tick(0);
    chk("bp_valid", dout_valid, 1);
    chk("bp_dout", dout, 8'h3C);
    chk("bp_level", rlevel, 2);
    tick(1); tick(1); tick(1);
    chk("bp_end_valid", dout_valid, 0);
    chk("bp_delivered", del_cnt, 19);

    // Wrap-around with random writer pacing and random consumer stalls.
    wraps = 0; msb_tog = 0;
    target = wr_cnt + 40;
    cyc = 0;
    while (del_cnt < target && cyc < 3000) begin
      if (wr_cnt < target && (wr_cnt - (del_cnt + (dout_valid ? 1 : 0))) < 16
          && $urandom_range(0, 2) != 0)
        write_word(8'($urandom));
      tick($urandom_range(0, 3) != 0);
      cyc++;
    end
    chk("wrap_done", del_cnt >= target, 1);
    chk("wrap_raddr", wraps >= 2, 1);
    chk("wrap_msb", msb_tog >= 1, 1);
    for (int i = 0; i < 4; i++) tick(1);
    chk("wrap_queue_empty", expq.size(), 0);

    // Last-word pop coincides with the next write pointer reaching wq2.
    write_word(8'h77);
    tick(1); tick(1);
    write_word(8'h88);
    tick(1);
    tick(1);
    chk("sim_pop_valid", dout_valid, 1);
    chk("sim_pop_dout", dout, 8'h77);
    tick(1);
    chk("sim_rempty", rempty, 0);
    tick(1);
    chk("sim_valid2", dout_valid, 1);
    chk("sim_dout2", dout, 8'h88);
    tick(1); tick(1);
    chk("sim_all_delivered", del_cnt, wr_cnt);
    chk("sim_final_rempty", rempty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_read_ctrl.md
Name: fifo_read_ctrl

Overview:
- Read-side controller for the asynchronous FIFO; the consumer end of the dual-port FIFO memory.
- Synchronises the write-domain Gray pointer into rclk, keeps the read pointer, and drives the memory read address.
- Produces a registered empty flag and a fill level.
- Presents popped words on a registered valid/ready output port.

Parameters:
- DATASIZE, 8, width of a FIFO word.
- ADDRSIZE, 4, memory address width; depth = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits.

Ports:
- rclk  input  1  read-domain clock; the only clock of this block.
- rrst  input  1  asynchronous, active-high reset.
- wptr  input  ADDRSIZE+1  write pointer, Gray-coded, launched from the wclk domain (asynchronous to rclk).
- rdata  input  DATASIZE  memory read data; combinational MEM[raddr].
- raddr  output  ADDRSIZE  memory read address.
- rptr  output  ADDRSIZE+1  registered Gray read pointer, sent to the write side for the full calculation.
- rempty  output  1  FIFO empty, registered.
- rlevel  output  ADDRSIZE+1  words held in memory from the read side's view (pessimistic).
- dout  output  DATASIZE  output data register.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout this cycle.

Behaviour:
- Reset (rrst=1, asynchronous):
  - Sync flops wq1 and wq2, rbin and rptr clear to 0.
  - rempty=1, dout_valid=0, dout=0. Therefore raddr=0 and rlevel=0.
  - Reset asserted mid-transfer discards any held word immediately.
  - Release is synchronous to the next rclk edge.
- Synchroniser: two flops, wq1<=wptr and wq2<=wq1. No other logic reads wptr directly.
- Pop condition: pop = !rempty && (!dout_valid || dout_ready). The pop is the only read-pointer increment.
- Pointer update:
  - rbinnext = rbin + pop, modulo 2**(ADDRSIZE+1).
  - rgraynext = (rbinnext>>1) ^ rbinnext.
  - Each edge: rbin<=rbinnext, rptr<=rgraynext.
  - raddr = rbin[ADDRSIZE-1:0]. It wraps from 2**ADDRSIZE-1 to 0, and the MSB toggles on wrap.
- Empty flag: rempty <= (rgraynext == wq2), registered.
  - Set in the same edge that pops the last word.
  - Cleared one rclk after wq2 changes.
- Output register, evaluated each edge:
  - If pop: dout<=rdata and dout_valid<=1.
  - Else if dout_valid && dout_ready: dout_valid<=0 and dout holds its value.
  - Simultaneous consume and pop gives back-to-back words with no bubble (one word per rclk at full throughput).
  - dout is stable while dout_valid && !dout_ready.
- Latency:
  - A write-pointer change reaches wq2 after 2 rclk edges.
  - rempty falls on edge 3.
  - dout_valid rises on edge 4 when the output register is empty.
- Fill level:
  - wbin_s = Gray-to-binary(wq2).
  - rlevel = wbin_s - rbin, modulo 2**(ADDRSIZE+1). Combinational from registers.
  - Never exceeds 2**ADDRSIZE.
  - Excludes the word held in dout.
- Ignored inputs: dout_ready while dout_valid=0 has no effect. wptr glitches are tolerated only by the Gray property; a single-bit change per write is guaranteed by the writer.

Test Plan:
- Reset check: assert rrst mid-operation -> immediately rempty=1, dout_valid=0, rptr=0, raddr=0, rlevel=0, with no rclk edge required.
- Single word: bench memory MEM[0]=8'hA5, wptr 0->1 (Gray 5'b00001), dout_ready=1.
  - rempty falls at edge 3 after the change.
  - dout=8'hA5 with dout_valid=1 at edge 4.
  - Then rempty=1, rptr=5'b00001, dout_valid=0 one edge later.
- Fill and drain: write 16 words 0x00..0x0F, wptr Gray for binary 16 = 5'b11000.
  - rlevel=16 after sync.
  - With dout_ready=1, 16 consecutive dout values 0x00..0x0F, one per rclk, no gaps.
  - Ends with rempty=1 and rptr=5'b11000.
- Backpressure: 3 words queued, dout_ready=0.
  - Exactly one pop: dout_valid=1, dout stable, rlevel=2.
  - Raise dout_ready for 3 cycles -> remaining words delivered in order, then dout_valid=0.
- Wrap-around: run 40 words through a depth-16 FIFO -> raddr wraps 15->0 twice, rptr MSB toggles, all data matches in order, and there is no false empty or overrun.
- Simultaneous events: the pop of the last word occurs in the same cycle as a new wptr increment arriving at wq2 -> rempty=0 on the next edge and the new word is delivered with no loss or duplication.
